// File: rtl/router_out_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_out_fifo: per-destination output buffer of the 1x3 router, with   |
// | header tags for packet tracking and a pulse on each packet's parity byte.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module router_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_done
);

    localparam int C_AW = $clog2(DEPTH);
    localparam logic [C_AW:0] C_FULL_CNT = (C_AW + 1)'(DEPTH);

    logic [C_AW-1:0]  wptr_q, wptr_d;
    logic [C_AW-1:0]  rptr_q, rptr_d;
    logic [C_AW:0]    count_q, count_d;
    logic [6:0]       pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             pkt_done_q, pkt_done_d;
    logic [DEPTH-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] byte_q [DEPTH];
    logic [WIDTH-1:0] byte_d [DEPTH];

    logic w_wr_ok;
    logic w_rd_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == C_FULL_CNT);
    assign valid_out = ~empty;
    assign data_out  = data_out_q;
    assign pkt_done  = pkt_done_q;

    assign w_wr_ok = write_enb && !full;
    assign w_rd_ok = read_enb && !empty;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        pkt_done_d = 1'b0;
        tag_d      = tag_q;
        byte_d     = byte_q;

        // Flush wins over any same-cycle read or write; storage is left alone.
        if (soft_reset) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (w_wr_ok) begin
                tag_d[wptr_q]  = lfd_state;
                byte_d[wptr_q] = data_in;
                wptr_d         = wptr_q + C_AW'(1);
            end
            if (w_rd_ok) begin
                data_out_d = byte_q[rptr_q];
                rptr_d     = rptr_q + C_AW'(1);
                // Header reload counts payload plus the trailing parity byte.
                if (tag_q[rptr_q]) begin
                    pkt_cnt_d = {1'b0, byte_q[rptr_q][7:2]} + 7'd1;
                end else if (pkt_cnt_q != 7'd0) begin
                    pkt_cnt_d  = pkt_cnt_q - 7'd1;
                    pkt_done_d = (pkt_cnt_q == 7'd1);
                end
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   count_d = count_q + (C_AW + 1)'(1);
                2'b01:   count_d = count_q - (C_AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
            pkt_done_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
            pkt_done_q <= pkt_done_d;
            tag_q      <= tag_d;
        end
    end

    // Data bytes carry no reset; only their tags need a known value.
    always_ff @(posedge clock) begin
        byte_q <= byte_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_router_out_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_router_out_fifo: directed and random stimulus against a queue model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_router_out_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       pkt_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of {tag, byte} plus a remaining-bytes counter.
    logic [8:0] m_q [$];
    int         m_pcnt = 0;
    logic [7:0] m_dout = 8'h00;
    logic       m_done = 1'b0;

    router_out_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .full       (full),
        .empty      (empty),
        .pkt_done   (pkt_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_pcnt = 0;
        m_dout = 8'h00;
        m_done = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic lfd, input logic [7:0] d,
                              input logic r, input logic sr);
        logic       do_rd;
        logic       do_wr;
        logic [8:0] e;
        if (sr) begin
            model_clear();
            return;
        end
        do_rd  = r && (m_q.size() != 0);
        do_wr  = w && (m_q.size() != 16);
        m_done = 1'b0;
        if (do_rd) begin
            e      = m_q.pop_front();
            m_dout = e[7:0];
            if (e[8]) begin
                m_pcnt = int'(e[7:2]) + 1;
            end else if (m_pcnt > 0) begin
                m_pcnt--;
                if (m_pcnt == 0) m_done = 1'b1;
            end
        end
        if (do_wr) m_q.push_back({lfd, d});
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
        check({tag, ".pkt_done"}, 32'(pkt_done), 32'(m_done));
        check({tag, ".empty"},    32'(empty),    32'(m_q.size() == 0));
        check({tag, ".full"},     32'(full),     32'(m_q.size() == 16));
        check({tag, ".valid"},    32'(valid_out), 32'(m_q.size() != 0));
    endtask

    // One clock: drive away from the edge, step the model at the edge, check just after.
    task automatic cyc(input string tag, input logic w, input logic lfd, input logic [7:0] d,
                       input logic r, input logic sr);
        write_enb  = w;
        lfd_state  = lfd;
        data_in    = d;
        read_enb   = r;
        soft_reset = sr;
        @(posedge clock);
        model_edge(w, lfd, d, r, sr);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        read_enb   = 1'b0;
        soft_reset = 1'b0;
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 reset = 1'b1;
        model_clear();
        #1;
        check({tag, ".empty"},    32'(empty),     32'd1);
        check({tag, ".full"},     32'(full),      32'd0);
        check({tag, ".valid"},    32'(valid_out), 32'd0);
        check({tag, ".data_out"}, 32'(data_out),  32'h00);
        check({tag, ".pkt_done"}, 32'(pkt_done),  32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset asserted while a write is in flight.
        cyc("pre", 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        write_enb = 1'b1;
        data_in   = 8'h5A;
        async_reset_pulse("rst_wr");

        // Full packet with continuous reads.
        cyc("p_h",  1'b1, 1'b1, 8'h0C, 1'b0, 1'b0);
        cyc("p_1",  1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        cyc("p_2",  1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        cyc("p_3",  1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        cyc("p_par", 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        cyc("r_h",  1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("pkt.hdr_out", 32'(data_out), 32'h0C);
        cyc("r_1",  1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc("r_2",  1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc("r_3",  1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("pkt.no_early_done", 32'(pkt_done), 32'd0);
        cyc("r_par", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("pkt.par_out",  32'(data_out), 32'h3C);
        check("pkt.par_done", 32'(pkt_done), 32'd1);
        cyc("r_after", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, drop an extra write, drain; twice so the pointers wrap.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 1'b0, 8'(8'h40 + i + rep * 16), 1'b0, 1'b0);
            check("fill.full", 32'(full), 32'd1);
            cyc("drop", 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
            cyc("drop_rw", 1'b1, 1'b0, 8'hEF, 1'b1, 1'b0);
            for (int i = 0; i < 15; i++) cyc("drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check("drain.empty", 32'(empty), 32'd1);
        end

        // Simultaneous read and write at count 5.
        for (int i = 0; i < 5; i++) cyc("sim_w", 1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("sim_rw", 1'b1, 1'b0, 8'(8'h90 + i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc("sim_r", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("sim.last", 32'(data_out), 32'h92);

        // Reads while empty hold data_out.
        for (int i = 0; i < 3; i++) cyc("erd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("erd.hold", 32'(data_out), 32'h92);

        // Flush at count 7 with a concurrent write.
        for (int i = 0; i < 7; i++) cyc("sr_w", 1'b1, 1'b0, 8'(8'hB0 + i), 1'b0, 1'b0);
        cyc("sr", 1'b1, 1'b0, 8'hCC, 1'b0, 1'b1);
        check("sr.empty", 32'(empty), 32'd1);
        cyc("sr_orph_w", 1'b1, 1'b0, 8'hD1, 1'b0, 1'b0);
        cyc("sr_orph_r", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("sr.orphan_nodone", 32'(pkt_done), 32'd0);

        // Async reset in the middle of a packet; remaining bytes become orphans.
        cyc("mp_h", 1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
        cyc("mp_1", 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        cyc("mp_rh", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        write_enb = 1'b1;
        data_in   = 8'h66;
        async_reset_pulse("rst_mid");
        cyc("mp_o1", 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        cyc("mp_o2", 1'b1, 1'b0, 8'hBB, 1'b1, 1'b0);
        cyc("mp_o3", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("mid.orphan_nodone", 32'(pkt_done), 32'd0);

        // Zero-length header: next byte is the parity byte.
        cyc("z_h", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc("z_p", 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0);
        cyc("z_r", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("zero.done", 32'(pkt_done), 32'd1);

        // Random traffic with short headers.
        for (int i = 0; i < 600; i++) begin
            logic       w, lfd, r, sr;
            logic [7:0] d;
            w   = ($urandom_range(0, 99) < 60);
            r   = ($urandom_range(0, 99) < 55);
            sr  = ($urandom_range(0, 99) < 2);
            lfd = ($urandom_range(0, 7) == 0);
            d   = 8'($urandom);
            if (lfd) d[7:2] = 6'($urandom_range(0, 4));
            cyc("rnd", w, lfd, d, r, sr);
        end

        idle_inputs();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
